// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the writer state encoding. The VGA reader
// wraps on the same FRAME_PIXELS, so both sides stay in step.
package fb_pkg;

  localparam int unsigned FRAME_PIXELS = 120000;  // 400x300
  localparam int unsigned DATA_W       = 12;      // RGB444
  localparam int unsigned ADDR_W       = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/frame_buf_writer_if.sv
// Pixel stream in and BRAM port-A write request out, bundled as one bus.
// master: the frame-buffer writer. slave: its surroundings (pixel source + BRAM).
interface frame_buf_writer_if;

  logic                      s_valid;
  logic                      s_ready;
  logic                      s_sof;
  logic [fb_pkg::DATA_W-1:0] s_data;

  logic                      wr_en;
  logic                      wr_ready;
  logic [fb_pkg::ADDR_W-1:0] wr_addr;
  logic [fb_pkg::DATA_W-1:0] wr_data;

  modport master (
    input  s_valid, s_sof, s_data, wr_ready,
    output s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output s_valid, s_sof, s_data, wr_ready,
    input  s_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/fb_wr_out_reg.sv
// One-deep write request register (addr + data + valid). Holds the request
// until the sink takes it; a new load on the completing cycle gives
// back-to-back throughput of one write per cycle.
module fb_wr_out_reg #(
  parameter int unsigned AW = fb_pkg::ADDR_W,
  parameter int unsigned DW = fb_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          free,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  // Register may take a new request when empty or when it drains this cycle.
  assign free = !valid || ready;

  // Load on request, otherwise drop valid once the sink has taken the write.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      valid <= 1'b0;
      // NOTE: the data path is reset too, so addr/data read 0 after reset rather than X.
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_buf_writer.sv
// Writes an RGB444 pixel stream into the frame buffer, one frame at a time,
// locking to s_sof and resynchronising on short frames or missing sof.
module frame_buf_writer #(
  parameter int unsigned FRAME_PIXELS = fb_pkg::FRAME_PIXELS
) (
  input  logic                clk_25mHz,
  input  logic                rst_n,
  input  logic                capture_en,
  input  logic                continuous,
  frame_buf_writer_if.master  bus,
  output logic                frame_done,
  output logic                frame_err,
  output logic [7:0]          frame_cnt,
  output logic                busy
);

  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pix_cnt, pix_cnt_n;
  logic [ADDR_W-1:0]   wr_idx;
  logic                do_write, done_n, err_n;
  logic                accept;
  logic                out_free, out_valid;
  logic [ADDR_W-1:0]   out_addr;
  logic [DATA_W-1:0]   out_data;

  assign bus.s_ready = (state != IDLE) && out_free;
  assign accept      = bus.s_valid && bus.s_ready;
  assign busy        = (state != IDLE) || out_valid;

  assign bus.wr_en   = out_valid;
  assign bus.wr_addr = out_addr;
  assign bus.wr_data = out_data;

  fb_wr_out_reg #(.AW(ADDR_W), .DW(DATA_W)) u_out_reg (
    .clk       (clk_25mHz),
    .rst_n     (rst_n),
    .load      (do_write),
    .load_addr (wr_idx),
    .load_data (bus.s_data),
    .ready     (bus.wr_ready),
    .free      (out_free),
    .valid     (out_valid),
    .addr      (out_addr),
    .data      (out_data)
  );

  // Next state: decide whether the accepted pixel is written, where, and
  // whether it closes or breaks a frame.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_n   = state;
    pix_cnt_n = pix_cnt;
    wr_idx    = pix_cnt;
    do_write  = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;

    unique case (state)
      IDLE: begin
        if (capture_en) state_n = SYNC;
      end
      SYNC: begin
        if (!capture_en) begin
          state_n = IDLE;
        end else if (accept && bus.s_sof) begin
          do_write = 1'b1;
          wr_idx   = '0;
          state_n  = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          if (bus.s_sof) begin
            // Start of frame; mid-frame sof means the previous frame was short.
            do_write = 1'b1;
            wr_idx   = '0;
            err_n    = (pix_cnt != '0);
          end else if (pix_cnt == '0) begin
            // Frame should have started here: drop the pixel and hunt for sof.
            err_n   = 1'b1;
            state_n = SYNC;
          end else begin
            do_write = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // The last index closes the frame; capture mode picks the follow-on state.
    if (do_write) begin
      if (wr_idx == LAST_IDX) begin
        done_n    = 1'b1;
        pix_cnt_n = '0;
        state_n   = (capture_en && continuous) ? WRITE : IDLE;
      end else begin
        pix_cnt_n = wr_idx + ADDR_W'(1);
      end
    end
  end

  // State, pixel counter, frame counter and status pulses.
  always_ff @(posedge clk_25mHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      pix_cnt    <= pix_cnt_n;
      frame_done <= done_n;
      frame_err  <= err_n;
      if (done_n) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule
